// File: rtl/adc_stats_pkg.sv
// Shared widths, FSM states and sample helpers
// for the per-channel ADC statistics engine.
package adc_stats_pkg;

  localparam int SAMPLE_W = 10;
  localparam int SAMPLES  = 8;
  localparam int NCH      = 4;
  localparam int PWR_W    = 48;
  localparam int SUM_W    = 40;
  localparam int SQ_W     = 19;
  localparam int TPWR_W   = 22;
  localparam int TSUM_W   = 13;
  localparam int WORD_W   = SAMPLE_W * SAMPLES;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DRAIN
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] to_signed(
    input logic [SAMPLE_W-1:0] code
  );
    return {~code[SAMPLE_W-1], code[SAMPLE_W-2:0]};
  endfunction

  function automatic logic [SAMPLE_W-1:0] mag_of(
    input logic signed [SAMPLE_W-1:0] s
  );
    logic [SAMPLE_W-1:0] u;
    u = s;
    return u[SAMPLE_W-1] ? (~u + 10'd1) : u;
  endfunction

endpackage

// File: rtl/adc_chan_stats_if.sv
// Result drain channel: one channel's statistics
// per valid/ready beat.
interface adc_chan_stats_if
  import adc_stats_pkg::*;
#(
  parameter int ACC_LEN_W = 24,
  parameter int SEQ_W     = 16
);

  logic                    res_valid;
  logic                    res_ready;
  logic [1:0]              res_chan;
  logic                    res_last;
  logic [SEQ_W-1:0]        res_seq;
  logic [PWR_W-1:0]        res_pwr;
  logic signed [SUM_W-1:0] res_sum;
  logic [SAMPLE_W-1:0]     res_peak;
  logic [ACC_LEN_W-1:0]    res_or_cnt;

  modport master (
    output res_valid, res_chan, res_last,
    output res_seq, res_pwr, res_sum,
    output res_peak, res_or_cnt,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_chan, res_last,
    input  res_seq, res_pwr, res_sum,
    input  res_peak, res_or_cnt,
    output res_ready
  );

endinterface

// File: rtl/adc_stats_lane.sv
// One channel: S1 square, S2 adder trees,
// S3 window accumulators and over-range count.
module adc_stats_lane
  import adc_stats_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    beat,
  input  logic                    clear,
  input  logic [WORD_W-1:0]       data,
  input  logic                    or_bit,
  output logic [PWR_W-1:0]        pwr,
  output logic signed [SUM_W-1:0] sum,
  output logic [SAMPLE_W-1:0]     peak,
  output logic [CNT_W-1:0]        or_cnt
);

  logic signed [SAMPLE_W-1:0] s0 [SAMPLES];
  logic signed [2*SAMPLE_W-1:0] p0 [SAMPLES];
  logic signed [SAMPLE_W-1:0] s1 [SAMPLES];
  logic [SQ_W-1:0]            sq1 [SAMPLES];
  logic                       v1;
  logic                       or1;

  logic [TPWR_W-1:0]          pwr_t;
  logic signed [TSUM_W-1:0]   sum_t;
  logic [SAMPLE_W-1:0]        pk_t;
  logic [SAMPLE_W-1:0]        mag [SAMPLES];

  logic [TPWR_W-1:0]          pwr2;
  logic signed [TSUM_W-1:0]   sum2;
  logic [SAMPLE_W-1:0]        pk2;
  logic                       v2;
  logic                       or2;

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      s0[i] = to_signed(data[i*SAMPLE_W +: SAMPLE_W]);
      p0[i] = s0[i] * s0[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      or1 <= 1'b0;
      for (int i = 0; i < SAMPLES; i++) begin
        s1[i]  <= '0;
        sq1[i] <= '0;
      end
    end else begin
      v1  <= beat;
      or1 <= beat & or_bit;
      if (beat) begin
        for (int i = 0; i < SAMPLES; i++) begin
          s1[i]  <= s0[i];
          sq1[i] <= p0[i][SQ_W-1:0];
        end
      end
    end
  end

  always_comb begin
    pwr_t = '0;
    sum_t = '0;
    pk_t  = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      mag[i] = mag_of(s1[i]);
      pwr_t  = pwr_t + TPWR_W'(sq1[i]);
      sum_t  = sum_t + TSUM_W'(s1[i]);
      if (mag[i] > pk_t) pk_t = mag[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      or2  <= 1'b0;
      pwr2 <= '0;
      sum2 <= '0;
      pk2  <= '0;
    end else begin
      v2   <= v1;
      or2  <= or1;
      pwr2 <= pwr_t;
      sum2 <= sum_t;
      pk2  <= pk_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr    <= '0;
      sum    <= '0;
      peak   <= '0;
      or_cnt <= '0;
    end else if (clear) begin
      pwr    <= '0;
      sum    <= '0;
      peak   <= '0;
      or_cnt <= '0;
    end else if (v2) begin
      pwr    <= pwr + PWR_W'(pwr2);
      sum    <= sum + SUM_W'(sum2);
      or_cnt <= or_cnt + CNT_W'(or2);
      if (pk2 > peak) peak <= pk2;
    end
  end

endmodule

// File: rtl/adc_chan_stats.sv
// Windowed per-channel power/DC/peak/over-range
// statistics with serial valid/ready readout.
module adc_chan_stats
  import adc_stats_pkg::*;
#(
  parameter int ACC_LEN_W = 24,
  parameter int SEQ_W     = 16
) (
  input  logic                 clk_div_a,
  input  logic                 sys_rst_n,
  input  logic                 flag,
  input  logic [WORD_W-1:0]    dataA_in,
  input  logic [WORD_W-1:0]    dataB_in,
  input  logic [WORD_W-1:0]    dataC_in,
  input  logic [WORD_W-1:0]    dataD_in,
  input  logic [3:0]           data_or,
  input  logic [ACC_LEN_W-1:0] acc_len,
  input  logic                 arm,
  input  logic                 continuous,
  output logic                 busy,
  adc_chan_stats_if.master     res
);

  state_t st, nxt;

  logic                    load, clr, copy, done;
  logic                    beat, fire;
  logic [ACC_LEN_W-1:0]    beat_cnt;
  logic [1:0]              fl_cnt;
  logic [1:0]              ch;
  logic [SEQ_W-1:0]        seq;

  logic [WORD_W-1:0]       din   [NCH];
  logic [PWR_W-1:0]        l_pwr [NCH];
  logic signed [SUM_W-1:0] l_sum [NCH];
  logic [SAMPLE_W-1:0]     l_pk  [NCH];
  logic [ACC_LEN_W-1:0]    l_or  [NCH];

  logic [PWR_W-1:0]        r_pwr [NCH];
  logic signed [SUM_W-1:0] r_sum [NCH];
  logic [SAMPLE_W-1:0]     r_pk  [NCH];
  logic [ACC_LEN_W-1:0]    r_or  [NCH];

  always_comb begin
    din[0] = dataA_in;
    din[1] = dataB_in;
    din[2] = dataC_in;
    din[3] = dataD_in;
  end

  assign beat = (st == ACCUM) && flag;
  assign fire = res.res_valid && res.res_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    adc_stats_lane #(
      .CNT_W(ACC_LEN_W)
    ) u_lane (
      .clk   (clk_div_a),
      .rst_n (sys_rst_n),
      .beat  (beat),
      .clear (clr),
      .data  (din[c]),
      .or_bit(data_or[c]),
      .pwr   (l_pwr[c]),
      .sum   (l_sum[c]),
      .peak  (l_pk[c]),
      .or_cnt(l_or[c])
    );
  end

  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) st <= IDLE;
    else            st <= nxt;
  end

  // FLUSH waits out S1..S3 so the copy sees the last beat
  always_comb begin
    nxt  = st;
    load = 1'b0;
    clr  = 1'b0;
    copy = 1'b0;
    done = 1'b0;
    unique case (st)
      IDLE: begin
        if (arm) begin
          nxt  = ACCUM;
          load = 1'b1;
          clr  = 1'b1;
        end
      end
      ACCUM: begin
        if (beat && beat_cnt == ACC_LEN_W'(1))
          nxt = FLUSH;
      end
      FLUSH: begin
        if (fl_cnt == 2'd2) begin
          nxt  = DRAIN;
          copy = 1'b1;
        end
      end
      DRAIN: begin
        if (fire && ch == 2'd3) begin
          done = 1'b1;
          if (continuous) begin
            nxt  = ACCUM;
            load = 1'b1;
            clr  = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_cnt <= '0;
      fl_cnt   <= '0;
      ch       <= '0;
      seq      <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_pwr[c] <= '0;
        r_sum[c] <= '0;
        r_pk[c]  <= '0;
        r_or[c]  <= '0;
      end
    end else begin
      if (load)
        beat_cnt <= (acc_len == '0) ?
                    ACC_LEN_W'(1) : acc_len;
      else if (beat)
        beat_cnt <= beat_cnt - ACC_LEN_W'(1);
      fl_cnt <= (st == FLUSH) ? fl_cnt + 2'd1 : 2'd0;
      if (st != DRAIN) ch <= 2'd0;
      else if (fire)   ch <= ch + 2'd1;
      if (done) seq <= seq + SEQ_W'(1);
      if (copy) begin
        for (int c = 0; c < NCH; c++) begin
          r_pwr[c] <= l_pwr[c];
          r_sum[c] <= l_sum[c];
          r_pk[c]  <= l_pk[c];
          r_or[c]  <= l_or[c];
        end
      end
    end
  end

  assign busy           = (st != IDLE);
  assign res.res_valid  = (st == DRAIN);
  assign res.res_chan   = ch;
  assign res.res_last   = (st == DRAIN) && (ch == 2'd3);
  assign res.res_seq    = seq;
  assign res.res_pwr    = r_pwr[ch];
  assign res.res_sum    = r_sum[ch];
  assign res.res_peak   = r_pk[ch];
  assign res.res_or_cnt = r_or[ch];

endmodule

// File: doc/adc_chan_stats.md
# adc_chan_stats

Per-channel signal statistics engine on the `clk_div_a` domain, directly downstream of the ADC front-end / data-process stage. It consumes the four 80-bit sample words (8 × 10-bit samples per cycle) plus valid `flag` and over-range bits. Over a programmable window it accumulates, per channel:
- sum of squares (power)
- sum (DC)
- peak magnitude
- over-range cycle count

At window end it drains the four channel results serially over a valid/ready interface for register readout.

## Interface
Parameters:
- `ACC_LEN_W`, 24, width of window length counter (beats)
- `SEQ_W`, 16, window sequence counter width

Ports:
- `clk_div_a`  in  1  sample clock, 156.25 MHz
- `sys_rst_n`  in  1  reset; asynchronous, active-low
- `flag`  in  1  input beat valid
- `dataA_in`, `dataB_in`, `dataC_in`, `dataD_in`  in  80 each  8 offset-binary samples; bits [10k+9:10k] = sample k, k=0 oldest
- `data_or`  in  4  over-range, bit0=A … bit3=D, qualified by `flag`
- `acc_len`  in  ACC_LEN_W  window length in valid beats; 0 treated as 1; sampled on arm
- `arm`  in  1  single-cycle start request
- `continuous`  in  1  re-arm automatically after drain
- `busy`  out  1  high in any state other than IDLE
- `res_valid`  out  1  result beat valid
- `res_ready`  in  1  consumer accepts beat
- `res_chan`  out  2  channel index 0..3 (A..D)
- `res_last`  out  1  high on channel 3 beat
- `res_seq`  out  SEQ_W  window number, +1 per completed window, wraps
- `res_pwr`  out  48  Σ s², unsigned
- `res_sum`  out  40  Σ s, signed
- `res_peak`  out  10  max |s|, range 0..512
- `res_or_cnt`  out  ACC_LEN_W  beats with the channel's `data_or` bit set

## Operation
- Sample conversion: s = {~code[9], code[8:0]}, signed −512..+511.
- Per-lane pipeline:
  - S1 registers s and s² (19-bit unsigned).
  - S2 registers the 8-input adder trees: Σs² 22 bits, Σs 13 bits signed, max|s|.
  - S3 accumulates. Accumulators are full width, no saturation; 48/40 bits cannot overflow at ACC_LEN_W=24.
- FSM states:
  - IDLE: `arm`=1 → load `acc_len`, clear accumulators and OR counters → ACCUM.
  - ACCUM: each cycle with `flag`=1 enters S1 and decrements the beat counter. `flag`=0 cycles are ignored entirely, including `data_or`. Last beat accepted → FLUSH.
  - FLUSH: 2 cycles; inputs ignored. Then copy accumulators to result registers → DRAIN.
  - DRAIN: present channels 0,1,2,3 in order. Advance on `res_valid`&&`res_ready`. After the ch3 handshake, `res_seq`++ and go → ACCUM if `continuous`=1 (reload `acc_len`, clear accumulators), else → IDLE.
- `arm` outside IDLE: ignored. `arm` and `continuous` together in IDLE: start normally.
- Input beats arriving during FLUSH/DRAIN are discarded, not buffered.
- Dropping `continuous` mid-window: the current window completes, then the FSM returns to IDLE.

## Timing
- All outputs reset to 0; FSM resets to IDLE.
- `sys_rst_n` assert mid-window or mid-drain aborts immediately. No partial result is emitted; `res_seq` returns to 0.
- Latency: the last beat is sampled at edge T. `res_valid` is high after edge T+3, with ch0 data.
- Handshake:
  - `res_valid` never deasserts without a handshake.
  - Data, `res_chan` and `res_last` are stable while `res_valid`=1 and `res_ready`=0.
  - With `res_ready` held high, the drain takes exactly 4 cycles.
- `busy` rises the cycle after `arm` is accepted and falls the cycle after the ch3 handshake (non-continuous).
- `acc_len`=1: window = one beat, FLUSH → DRAIN as normal.

## Structure
- Package `adc_stats_pkg`:
  - FSM state enum {IDLE, ACCUM, FLUSH, DRAIN}
  - widths: SAMPLE_W=10, SAMPLES=8, PWR_W=48, SUM_W=40
  - offset-to-signed conversion function
- Sub-module `adc_stats_lane`, instantiated 4× (one per channel). It contains S1–S3 and the accumulators, with ports for beat-in, clear and OR bit.
- Top level contains the FSM, beat counter, result registers, drain mux and seq counter.

## Test plan
- All samples 0x200, `acc_len`=4, `flag` always 1:
  - every channel: pwr=0, sum=0, peak=0, or_cnt=0
  - `res_seq`=0 on the first window
- Ch A 0x3FF, ch B 0x000, `acc_len`=4:
  - A: pwr=8355872, sum=16352, peak=511
  - B: pwr=8388608, sum=−16384, peak=512
- `flag` toggling 1010…, `acc_len`=4: results match the contiguous case; `res_valid` appears 3 cycles after the 4th valid beat.
- `data_or`=4'b0101 on 3 of 10 beats: or_cnt A=3, C=3, B=0, D=0.
- `res_ready` low 5 cycles on ch1: outputs hold; order remains 0,1,2,3 with `res_last` only on ch3. `continuous`=1: next window starts after ch3 and `res_seq` increments.
- `sys_rst_n` low during ACCUM and again during DRAIN: outputs are 0 the next cycle, no stale beats afterwards, and a clean window runs after re-arm.
